mem_access_ctrl: RTL and testbench

- Memory-stage controller between the EX/MEM pipeline register and the byte-addressed data memory.
- Accepts one load/store request at a time over a valid/ready handshake.
- Checks alignment and range, then drives the memory's DAddr/DataIn/Load/Store/mRD/mWR controls for exactly one cycle.
- Returns load results to MEM/WB with a one-cycle wb_valid pulse; no memory transaction ever overlaps another.

---
 rtl/mem_access_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: memory-stage controller between EX/MEM and a byte-addressed data memory.
// Build option MEM_MISALIGN_TRAP_EN: bad accesses trap instead of proceeding force-aligned.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] DAddr,
  output logic [31:0] DataIn,
  output logic [2:0]  Load,
  output logic [1:0]  Store,
  output logic        mRD,
  output logic        mWR,
  input  logic [31:0] DataOut,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        st_done,
  output logic        misalign_err,
  output logic        trap_valid,
  output logic [31:0] trap_addr,
  input  logic        trap_ack
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
`ifdef MEM_MISALIGN_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic [4:0]  rd_q;
  logic        err_q;
  logic        flush_q;

  logic        hs;
  logic [2:0]  req_bytes;
  logic [32:0] req_last;
  logic        req_misalign;
  logic        req_oor;
  logic        req_bad;
  logic [31:0] req_addr_lat;

  // Request decode: size 3 behaves as a word everywhere.
  always_comb begin
    req_bytes = 3'd4;
    unique case (req_size)
      2'd0:    req_bytes = 3'd1;
      2'd1:    req_bytes = 3'd2;
      default: req_bytes = 3'd4;
    endcase
    req_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));
    req_last     = {1'b0, req_addr} + {30'd0, req_bytes - 3'd1};
    req_oor      = ((req_last >> ADDR_W) != 33'd0);
    req_bad      = req_misalign || req_oor;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Bad accesses never reach ACCESS, so the raw address doubles as trap_addr.
  assign req_addr_lat = req_addr;
`else
  logic [31:0] addr_mask;
  logic [31:0] req_aligned;
  logic        unused_trap_ack;

  assign addr_mask       = (32'd1 << ADDR_W) - 32'd1;
  assign req_aligned     = req_size[1]        ? {req_addr[31:2], 2'b00} :
                           (req_size == 2'd1) ? {req_addr[31:1], 1'b0}  : req_addr;
  assign req_addr_lat    = req_aligned & addr_mask;
  assign unused_trap_ack = trap_ack;
`endif

  assign req_ready = rst_n && (state_q == IDLE);
  assign hs        = (state_q == IDLE) && req_valid && !flush;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
`ifdef MEM_MISALIGN_TRAP_EN
          state_d = req_bad ? TRAP : ACCESS;
`else
          state_d = ACCESS;
`endif
        end
      end
      ACCESS:  state_d = we_q ? IDLE : RESP;
      RESP:    state_d = IDLE;
`ifdef MEM_MISALIGN_TRAP_EN
      TRAP:    if (trap_ack) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= hs && req_bad;
      flush_q <= flush;
      if (hs) begin
        addr_q  <= req_addr_lat;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        we_q    <= req_we;
        rd_q    <= req_rd;
      end
    end
  end

  assign misalign_err = err_q;

  always_comb begin
    DAddr      = '0;
    DataIn     = '0;
    Load       = 3'b100;
    Store      = 2'b10;
    mRD        = 1'b0;
    mWR        = 1'b0;
    wb_valid   = 1'b0;
    wb_rd      = '0;
    wb_data    = '0;
    st_done    = 1'b0;
    trap_valid = 1'b0;
    trap_addr  = '0;
    unique case (state_q)
      ACCESS: begin
        DAddr  = addr_q;
        DataIn = wdata_q;
        unique case (size_q)
          2'd0:    begin Load = uns_q ? 3'b001 : 3'b000; Store = 2'b00; end
          2'd1:    begin Load = uns_q ? 3'b011 : 3'b010; Store = 2'b01; end
          default: begin Load = 3'b100;                  Store = 2'b10; end
        endcase
        if (we_q) begin
          mWR     = 1'b1;
          st_done = 1'b1;
        end else begin
          mRD = 1'b1;
        end
      end
      RESP: begin
        // Flush seen on the entry edge or during RESP squashes the writeback.
        wb_valid = !(flush_q || flush);
        wb_rd    = rd_q;
        wb_data  = DataOut;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      TRAP: begin
        trap_valid = 1'b1;
        trap_addr  = addr_q;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed steps plus random requests against a byte-array model.
module tb_mem_access_ctrl;
  localparam int unsigned AW = 10;
  localparam int unsigned MEM_BYTES = 1 << AW;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic [2:0]  Load;
  logic [1:0]  Store;
  logic        mRD;
  logic        mWR;
  logic [31:0] DataOut;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_done;
  logic        misalign_err;
  logic        trap_valid;
  logic [31:0] trap_addr;
  logic        trap_ack;

  int checks = 0;
  int failures = 0;
  int overlap = 0;

  logic [7:0] mem [MEM_BYTES];
  bit   [7:0] ref_mem [MEM_BYTES];

  mem_access_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .DAddr(DAddr), .DataIn(DataIn), .Load(Load), .Store(Store),
    .mRD(mRD), .mWR(mWR), .DataOut(DataOut),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_done(st_done), .misalign_err(misalign_err),
    .trap_valid(trap_valid), .trap_addr(trap_addr), .trap_ack(trap_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: sampled read on posedge, write on negedge, loads extended here.
  int unsigned ra, wa;
  always @(posedge clk) begin
    if (mRD) begin
      ra = DAddr % MEM_BYTES;
      case (Load)
        3'b000:  DataOut <= {{24{mem[ra][7]}}, mem[ra]};
        3'b001:  DataOut <= {24'd0, mem[ra]};
        3'b010:  DataOut <= {{16{mem[ra+1][7]}}, mem[ra+1], mem[ra]};
        3'b011:  DataOut <= {16'd0, mem[ra+1], mem[ra]};
        default: DataOut <= {mem[ra+3], mem[ra+2], mem[ra+1], mem[ra]};
      endcase
    end
  end

  always @(negedge clk) begin
    if (mRD && mWR) overlap++;
    if (mWR) begin
      wa = DAddr % MEM_BYTES;
      mem[wa] = DataIn[7:0];
      if (Store != 2'b00) mem[wa+1] = DataIn[15:8];
      if (Store == 2'b10) begin
        mem[wa+2] = DataIn[23:16];
        mem[wa+3] = DataIn[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request through the full handshake, checked against the byte-array reference.
  task automatic do_req(input bit we, input bit [1:0] size, input bit uns,
                        input bit [31:0] addr, input bit [31:0] wdata,
                        input bit [4:0] rd, output logic [31:0] got);
    int unsigned nb;
    bit          bad;
    bit [31:0]   eff;
    bit [31:0]   exp_val;
    nb  = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    bad = ((addr % nb) != 0) || ((64'(addr) + 64'(nb) - 64'd1) >= 64'(MEM_BYTES));
    eff = (addr - (addr % nb)) % MEM_BYTES;
    got = '0;
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if (bad) begin
      check("trap_err", {31'd0, misalign_err}, 32'd1);
      check("trap_valid", {31'd0, trap_valid}, 32'd1);
      check("trap_addr", trap_addr, addr);
      check("trap_nostrobe", {30'd0, mRD, mWR}, 32'd0);
      check("trap_ready", {31'd0, req_ready}, 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("trap_hold", {31'd0, trap_valid}, 32'd1);
      trap_ack = 1'b1;
      step();
      trap_ack = 1'b0;
      check("trap_clear", {31'd0, trap_valid}, 32'd0);
      check("trap_ready_back", {31'd0, req_ready}, 32'd1);
      return;
    end
`endif
    check("err", {31'd0, misalign_err}, {31'd0, bad});
    check("daddr", DAddr, eff);
    check("strobes", {30'd0, mRD, mWR}, we ? 32'd1 : 32'd2);
    check("ready_busy", {31'd0, req_ready}, 32'd0);
    check("wbv_access", {31'd0, wb_valid}, 32'd0);
    if (we) begin
      check("store_code", {30'd0, Store}, (nb == 1) ? 32'd0 : (nb == 2) ? 32'd1 : 32'd2);
      check("datain", DataIn, wdata);
      check("st_done", {31'd0, st_done}, 32'd1);
      for (int unsigned i = 0; i < nb; i++) ref_mem[eff + i] = 8'((wdata >> (8 * i)) & 32'hFF);
      step();
      check("st_after", {29'd0, st_done, mWR, misalign_err}, 32'd0);
    end else begin
      check("load_code", {29'd0, Load}, (nb == 4) ? 32'd4 : ((nb == 1) ? 32'd0 : 32'd2) + 32'(uns));
      check("st_done_ld", {31'd0, st_done}, 32'd0);
      exp_val = 0;
      for (int unsigned i = 0; i < nb; i++) exp_val = exp_val + (32'(ref_mem[eff + i]) << (8 * i));
      if (nb < 4 && !uns && (((exp_val >> (8 * nb - 1)) & 1) != 0))
        exp_val = exp_val - (32'd1 << (8 * nb));
      step();
      check("wb_valid", {31'd0, wb_valid}, 32'd1);
      check("wb_data", wb_data, exp_val);
      check("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
      check("resp_nostrobe", {30'd0, mRD, mWR}, 32'd0);
      got = wb_data;
      step();
      check("wb_pulse", {31'd0, wb_valid}, 32'd0);
    end
  endtask

  logic [31:0] got;
  int unsigned sel;
  bit [31:0]   raddr;

  initial begin
    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'h00;
    DataOut = '0;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0; trap_ack = 1'b0;
    step();
    step();
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_strobes", {30'd0, mRD, mWR}, 32'd0);
    check("rst_pulses", {28'd0, wb_valid, st_done, misalign_err, trap_valid}, 32'd0);
    check("rst_daddr", DAddr, 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0, got);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd7, got);
    check("lw_const", got, 32'hDEADBEEF);
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h00000080, 5'd0, got);
    do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, 5'd1, got);
    check("lb_const", got, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 5'd2, got);
    check("lbu_const", got, 32'h00000080);
    do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 5'd3, got);
    check("lh_const", got, 32'hFFFF8000);
    do_req(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 5'd4, got);
    do_req(1'b1, 2'd2, 1'b0, 32'h3FE, 32'h12345678, 5'd0, got);

    // Back-to-back loads with req_valid held: second handshake three edges later.
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_rd = 5'd9;
    req_valid = 1'b1;
    check("b2b_ready0", {31'd0, req_ready}, 32'd1);
    step();
    check("b2b_acc", {30'd0, req_ready, mRD}, 32'd1);
    step();
    check("b2b_resp", {29'd0, req_ready, mRD, wb_valid}, 32'd1);
    step();
    check("b2b_idle", {30'd0, req_ready, mRD}, 32'd2);
    step();
    req_valid = 1'b0;
    check("b2b_acc2", {30'd0, req_ready, mRD}, 32'd1);
    step();
    check("b2b_wb2", wb_valid ? wb_data : 32'hBAD0BAD0, 32'hDEADBEEF);
    step();

    // Flush in IDLE holds off the handshake until it drops.
    req_addr = 32'h21; req_size = 2'd0; req_unsigned = 1'b1; req_valid = 1'b1; flush = 1'b1;
    step();
    check("flush_idle", {30'd0, req_ready, mRD}, 32'd2);
    flush = 1'b0;
    step();
    req_valid = 1'b0;
    check("flush_accept", {31'd0, mRD}, 32'd1);
    step();
    check("flush_accept_wb", {31'd0, wb_valid}, 32'd1);
    step();

    // Flush during RESP, then flush sampled on the edge entering RESP.
    req_valid = 1'b1; req_size = 2'd2; req_addr = 32'h10;
    step();
    req_valid = 1'b0;
    step();
    flush = 1'b1;
    #1;
    check("flush_resp", {31'd0, wb_valid}, 32'd0);
    step();
    flush = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check("flush_entry", {31'd0, wb_valid}, 32'd0);
    step();

    // Reset during ACCESS of a load.
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("rst_acc_rd", {31'd0, mRD}, 32'd1);
    rst_n = 1'b0;
    step();
    check("rst_acc_out", {26'd0, req_ready, mRD, mWR, wb_valid, st_done, misalign_err}, 32'd0);
    check("rst_acc_addr", DAddr | wb_data, 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_acc_nowb", {30'd0, req_ready, wb_valid}, 32'd2);

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      raddr = 32'($urandom_range(0, 63));
      else if (sel < 8) raddr = 32'($urandom_range(MEM_BYTES - 8, MEM_BYTES + 3));
      else if (sel < 9) raddr = 32'($urandom_range(0, MEM_BYTES - 1));
      else              raddr = $urandom;
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             raddr, $urandom, 5'($urandom_range(0, 31)), got);
    end

    check("no_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
